i2s_tx_sequencer: RTL and testbench

// - Sequences the I2S transmit datapath from the MCLK-domain clock divider's look-ahead strobes.
// - Accepts one stereo frame per LRCLK period via valid/ready and serialises it MSB-first onto SDATA.
// - Uses standard I2S framing: LRCLK low = left, one-SCLK data delay, 32-bit slots, 64 SCLK per frame.
// - Sits between the sample source/FIFO and the codec pins, next to the divider that drives SCLK/LRCLK.

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_tx_sequencer_if.sv | 25 ++
 rtl/i2s_tx_shifter.sv | 51 +++++
 rtl/i2s_tx_sequencer.sv | 110 +++++++++++
 tb/tb_i2s_tx_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, FSM state type and word-format helper for the I2S transmit path.
package i2s_pkg;

  localparam int unsigned SLOT_BITS      = 32;
  localparam int unsigned MCLK_PER_SCLK  = 8;
  localparam int unsigned SCLK_PER_FRAME = 64;
  localparam int unsigned BIT_CNT_W      = $clog2(SLOT_BITS);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SLOT_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } i2s_state_t;

  // Left-justify a zero-extended sample of the given width inside one slot word.
  function automatic logic [SLOT_BITS-1:0] left_justify(input logic [SLOT_BITS-1:0] sample,
                                                        input int unsigned width);
    return sample << (SLOT_BITS - width);
  endfunction

endpackage

// File: rtl/i2s_tx_sequencer_if.sv
// Stereo frame handshake between the sample source and the I2S transmit sequencer.
interface i2s_tx_sequencer_if #(
  parameter int unsigned WIDTH = 24
) ();

  logic [WIDTH-1:0] s_left;
  logic [WIDTH-1:0] s_right;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output s_left,
    output s_right,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_left,
    input  s_right,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/i2s_tx_shifter.sv
// Slot shift register, held right word and SDATA flop; driven by load/swap/shift controls.
module i2s_tx_shifter
  import i2s_pkg::*;
(
  input  logic                 MCLK,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 swap_i,
  input  logic                 shift_i,
  input  logic [SLOT_BITS-1:0] left_word_i,
  input  logic [SLOT_BITS-1:0] right_word_i,
  output logic                 sdata_o
);

  logic [SLOT_BITS-1:0] shreg_q, shreg_d;
  logic [SLOT_BITS-1:0] held_q, held_d;
  logic                 sdata_q, sdata_d;

  // Every action first emits the current MSB, which yields the one-bit I2S delay.
  always_comb begin
    shreg_d = shreg_q;
    held_d  = held_q;
    sdata_d = sdata_q;
    if (load_i) begin
      sdata_d = shreg_q[SLOT_BITS-1];
      shreg_d = left_word_i;
      held_d  = right_word_i;
    end else if (swap_i) begin
      sdata_d = shreg_q[SLOT_BITS-1];
      shreg_d = held_q;
    end else if (shift_i) begin
      sdata_d = shreg_q[SLOT_BITS-1];
      shreg_d = shreg_q << 1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      shreg_q <= '0;
      held_q  <= '0;
      sdata_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      held_q  <= held_d;
      sdata_q <= sdata_d;
    end
  end

  assign sdata_o = sdata_q;

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: frame handshake, slot FSM, underrun counting and framing checks,
// all paced by the clock divider's look-ahead strobes.
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 16
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             sclk_fall_stb,
  input  logic             lrclk_rise_stb,
  input  logic             lrclk_fall_stb,
  i2s_tx_sequencer_if.slave s_if,
  output logic             SDATA,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic             sync_err
);

  i2s_state_t           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 underrun_q, underrun_d;
  logic [CNT_W-1:0]     underrun_cnt_q, underrun_cnt_d;
  logic                 sync_err_q, sync_err_d;

  logic                 load, swap, shift, accept, lr_stb;
  logic [SLOT_BITS-1:0] left_word, right_word;

  assign s_if.s_ready = lrclk_fall_stb && enable && !reset;

  assign accept     = enable && s_if.s_valid;
  assign left_word  = accept ? left_justify(SLOT_BITS'(s_if.s_left), WIDTH) : '0;
  assign right_word = accept ? left_justify(SLOT_BITS'(s_if.s_right), WIDTH) : '0;
  assign lr_stb     = lrclk_fall_stb || lrclk_rise_stb;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    underrun_d     = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    sync_err_d     = sync_err_q;
    load           = 1'b0;
    swap           = 1'b0;
    shift          = 1'b0;

    // The fall action wins over everything, including a coincident rise strobe.
    if (lrclk_fall_stb) begin
      load      = 1'b1;
      state_d   = LEFT;
      bit_cnt_d = '0;
      if (enable && !s_if.s_valid) begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != '1) begin
          underrun_cnt_d = underrun_cnt_q + 1'b1;
        end
      end
    end else if (lrclk_rise_stb && state_q != IDLE) begin
      swap      = 1'b1;
      bit_cnt_d = '0;
      if (state_q == LEFT) begin
        state_d = RIGHT;
      end
    end else if (sclk_fall_stb && !lrclk_rise_stb && state_q != IDLE) begin
      shift     = 1'b1;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (state_q != IDLE && lr_stb &&
        (bit_cnt_q != LAST_BIT || !sclk_fall_stb ||
         (lrclk_rise_stb && lrclk_fall_stb) ||
         (lrclk_rise_stb && state_q == RIGHT) ||
         (lrclk_fall_stb && state_q == LEFT))) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      sync_err_q     <= sync_err_d;
    end
  end

  i2s_tx_shifter u_shifter (
    .MCLK         (MCLK),
    .reset        (reset),
    .load_i       (load),
    .swap_i       (swap),
    .shift_i      (shift),
    .left_word_i  (left_word),
    .right_word_i (right_word),
    .sdata_o      (SDATA)
  );

  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: divider-paced directed and random frames against a bit-level
// reference model plus an independent SCLK-rise receiver.
module tb_i2s_tx_sequencer;
  import i2s_pkg::*;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned CNT_W = 2;
  localparam int FRAME = MCLK_PER_SCLK * SCLK_PER_FRAME;
  localparam int HALF  = FRAME / 2;

  logic             MCLK = 1'b0;
  logic             reset, enable, sclk_fall_stb, lrclk_rise_stb, lrclk_fall_stb;
  logic             SDATA, underrun, sync_err;
  logic [CNT_W-1:0] underrun_cnt;

  i2s_tx_sequencer_if #(.WIDTH(WIDTH)) s_if ();

  i2s_tx_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .MCLK           (MCLK),
    .reset          (reset),
    .enable         (enable),
    .sclk_fall_stb  (sclk_fall_stb),
    .lrclk_rise_stb (lrclk_rise_stb),
    .lrclk_fall_stb (lrclk_fall_stb),
    .s_if           (s_if),
    .SDATA          (SDATA),
    .underrun       (underrun),
    .underrun_cnt   (underrun_cnt),
    .sync_err       (sync_err)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;
  int phase;
  bit inj_fall, primed, rx_en, pend_ok;
  int rdy_seen, ur_seen;
  logic [WIDTH-1:0] pend_l, pend_r, rx_l, rx_r;

  // Reference model: current slot word and how many of its bits have been sent.
  logic [31:0]      m_word, m_hold;
  int               m_n;
  bit               m_run, m_right;
  logic             m_sdata, m_ur, m_err;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic emit(input logic [31:0] w, input int n);
    if (n < 32) return w[5'(31 - n)];
    return 1'b0;
  endfunction

  function automatic logic [31:0] slot_word(input logic [WIDTH-1:0] s);
    return 32'(s) << (32 - WIDTH);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_word = '0; m_hold = '0; m_n = 0; m_run = 0; m_right = 0;
      m_sdata = 0; m_ur = 0; m_err = 0; m_cnt = '0;
    end else begin
      m_ur = 0;
      if (lrclk_fall_stb) begin
        if (m_run && (lrclk_rise_stb || !sclk_fall_stb || m_n % 32 != 31 || !m_right)) m_err = 1;
        m_sdata = emit(m_word, m_n);
        if (enable && s_if.s_valid) begin
          m_word = slot_word(s_if.s_left);
          m_hold = slot_word(s_if.s_right);
        end else begin
          m_word = '0;
          m_hold = '0;
        end
        if (enable && !s_if.s_valid) begin
          m_ur = 1;
          if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        m_n = 0; m_run = 1; m_right = 0;
      end else if (m_run && lrclk_rise_stb) begin
        if (!sclk_fall_stb || m_n % 32 != 31 || m_right) m_err = 1;
        m_sdata = emit(m_word, m_n);
        m_word = m_hold; m_n = 0; m_right = 1;
      end else if (m_run && sclk_fall_stb) begin
        m_sdata = emit(m_word, m_n);
        m_n++;
      end
    end
  endtask

  task automatic cycle();
    int k;
    sclk_fall_stb  = (phase % MCLK_PER_SCLK == MCLK_PER_SCLK - 1);
    lrclk_rise_stb = (phase == HALF - 1);
    lrclk_fall_stb = (phase == FRAME - 1) || inj_fall;
    #1;
    chk("s_ready", 32'(s_if.s_ready), 32'(lrclk_fall_stb && enable && !reset));
    if (primed) begin
      chk("sdata", 32'(SDATA), 32'(m_sdata));
      chk("underrun", 32'(underrun), 32'(m_ur));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
      chk("sync_err", 32'(sync_err), 32'(m_err));
      if (underrun === 1'b1) ur_seen++;
    end
    if (s_if.s_ready === 1'b1) rdy_seen++;
    // Receiver samples mid SCLK period; period 0 of each slot is the delay bit.
    if (phase % MCLK_PER_SCLK == MCLK_PER_SCLK / 2) begin
      k = phase / MCLK_PER_SCLK;
      if (k >= 1 && k <= WIDTH) rx_l = {rx_l[WIDTH-2:0], SDATA};
      else if (k >= 33 && k <= 32 + WIDTH) rx_r = {rx_r[WIDTH-2:0], SDATA};
    end
    if (phase == FRAME - 12) begin
      if (pend_ok && rx_en) begin
        chk("rx_left", 32'(rx_l), 32'(pend_l));
        chk("rx_right", 32'(rx_r), 32'(pend_r));
      end
      rx_l = '0;
      rx_r = '0;
    end
    if (phase == FRAME - 1) begin
      pend_ok = rx_en && !reset;
      pend_l  = (enable && s_if.s_valid) ? s_if.s_left : '0;
      pend_r  = (enable && s_if.s_valid) ? s_if.s_right : '0;
    end
    model_step();
    @(posedge MCLK);
    #1;
    primed   = 1;
    phase    = (phase + 1) % FRAME;
    inj_fall = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int p);
    while (phase != p) cycle();
  endtask

  initial begin
    phase = FRAME - 2; inj_fall = 0; primed = 0; rx_en = 1; pend_ok = 0;
    rdy_seen = 0; ur_seen = 0; rx_l = '0; rx_r = '0; pend_l = '0; pend_r = '0;
    reset = 1; enable = 1;
    s_if.s_valid = 0; s_if.s_left = '0; s_if.s_right = '0;
    sclk_fall_stb = 0; lrclk_rise_stb = 0; lrclk_fall_stb = 0;
    cycles(2);
    chk("rst_sdata", 32'(SDATA), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    reset = 0;

    // 1: fixed pattern held valid, one accept per frame
    s_if.s_left = 24'hA5A5A5; s_if.s_right = 24'h3C3C3C; s_if.s_valid = 1;
    rdy_seen = 0;
    cycles(3 * FRAME);
    chk("s1_ready_pulses", 32'(rdy_seen), 32'd3);

    // 2: extreme samples, MSB timing and right LSB position
    s_if.s_left = 24'h800001; s_if.s_right = 24'h7FFFFF;
    cycles(FRAME);
    run_to(7);
    chk("s2_delay_bit", 32'(SDATA), 32'd0);
    cycle();
    chk("s2_msb", 32'(SDATA), 32'd1);
    run_to(452);
    chk("s2_right_lsb", 32'(SDATA), 32'd1);
    run_to(460);
    chk("s2_right_pad", 32'(SDATA), 32'd0);

    // 3: three starved frames, recovery, then counter saturation
    s_if.s_valid = 0; ur_seen = 0;
    cycles(3 * FRAME);
    chk("s3_underruns", 32'(ur_seen), 32'd3);
    chk("s3_cnt", 32'(underrun_cnt), 32'd3);
    s_if.s_left = 24'($urandom); s_if.s_right = 24'($urandom); s_if.s_valid = 1;
    cycles(2 * FRAME);
    s_if.s_valid = 0; ur_seen = 0;
    cycles(FRAME);
    chk("s3_underrun_sat", 32'(ur_seen), 32'd1);
    chk("s3_cnt_sat", 32'(underrun_cnt), 32'd3);

    // 4: disabled source, then enable mid-frame
    enable = 0; s_if.s_valid = 1; rdy_seen = 0; ur_seen = 0;
    cycles(FRAME);
    chk("s4_no_ready", 32'(rdy_seen), 32'd0);
    chk("s4_no_underrun", 32'(ur_seen), 32'd0);
    run_to(100);
    enable = 1;
    run_to(FRAME - 1);
    chk("s4_no_early_accept", 32'(rdy_seen), 32'd0);
    cycle();
    chk("s4_accept_at_boundary", 32'(rdy_seen), 32'd1);

    // random frames
    for (int f = 0; f < 6; f++) begin
      s_if.s_left  = 24'($urandom);
      s_if.s_right = 24'($urandom);
      s_if.s_valid = ($urandom_range(0, 3) != 0);
      enable       = ($urandom_range(0, 5) != 0);
      cycles(FRAME);
    end

    // 5: early left boundary at bit_cnt 10
    rx_en = 0; enable = 1; s_if.s_valid = 1;
    run_to(0);
    run_to(8 * 10 + 7);
    s_if.s_left = 24'($urandom); s_if.s_right = 24'($urandom);
    inj_fall = 1;
    cycle();
    chk("s5_sync_err", 32'(sync_err), 32'd1);
    cycles(FRAME + 20);
    chk("s5_sync_err_sticky", 32'(sync_err), 32'd1);

    // 6: reset in the right slot, resume at the next left boundary
    run_to(300);
    reset = 1;
    cycle();
    reset = 0;
    chk("s6_sdata", 32'(SDATA), 32'd0);
    chk("s6_sync_err", 32'(sync_err), 32'd0);
    chk("s6_cnt", 32'(underrun_cnt), 32'd0);
    rx_en = 1;
    s_if.s_left = 24'($urandom); s_if.s_right = 24'($urandom);
    cycles(2 * FRAME + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
